core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV64 NPC datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It drives the instruction/data memory request handshakes and the PC, IR and register-file write enables. It also regenerates alu_src/alu_op from the latched opcode and halts on EBREAK, an illegal opcode or a bus timeout.

---
 rtl/core_seq_ctrl_pkg.sv | 40 ++++
 rtl/core_seq_ctrl_opcode_dec.sv | 52 +++++
 rtl/core_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states, trap causes, ALU codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package core_seq_ctrl_pkg;

  // RV64 major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_EBREAK   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_EBREAK  = 2'b01,
    TRAP_ILLEGAL = 2'b10,
    TRAP_BUS     = 2'b11
  } trap_e;

  localparam logic [2:0] ALU_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_OP_IMM  = 3'b011;

endpackage

// File: rtl/core_seq_ctrl_opcode_dec.sv
// Opcode classifier: legality, memory access type, rd writeback and ALU control.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: op_i (opcode) in; is_legal, is_mem, is_store, wr_rd, alu_src, alu_op out.
module seq_opcode_dec
  import core_seq_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic       is_legal,
  output logic       is_mem,
  output logic       is_store,
  output logic       wr_rd,
  output logic       alu_src,
  output logic [2:0] alu_op
);

  always_comb begin
    is_legal = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    wr_rd    = 1'b0;
    alu_src  = 1'b0;
    alu_op   = ALU_OP_NONE;
    case (op_i)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM32, OPC_OP, OPC_OP_32, OPC_JAL, OPC_JALR: begin
        is_legal = 1'b1;
        wr_rd    = 1'b1;
      end
      OPC_OP_IMM: begin
        is_legal = 1'b1;
        wr_rd    = 1'b1;
        alu_src  = 1'b1;
        alu_op   = ALU_OP_IMM;
      end
      OPC_LOAD: begin
        is_legal = 1'b1;
        is_mem   = 1'b1;
        wr_rd    = 1'b1;
      end
      OPC_STORE: begin
        is_legal = 1'b1;
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPC_BRANCH, OPC_EBREAK: begin
        is_legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB with halt on ebreak, illegal op or bus timeout.
// Latency: 4 cycles per ALU/branch/jump instruction, 5 per load/store, +1 per memory wait cycle.
// Backpressure: imem_req/dmem_req are levels held until ack; a request un-acked for BUS_TIMEOUT cycles halts the core.
// Ports: clk, rst (async, active high); inst/imem_ack in, imem_req/ir_we out (instruction side);
//        dmem_ack in, dmem_req/dmem_we out (data side); pc_we, rf_we, alu_src, alu_op datapath controls;
//        halt, trap, instret, state_o status.
// BUS_TIMEOUT must be >= 1 and fit in CNT_W bits.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        halt,
  output logic [1:0]  trap,
  output logic [63:0] instret,
  output logic [2:0]  state_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(BUS_TIMEOUT);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      instret_q, instret_d;
  trap_e            trap_q, trap_d;

  // Moore outputs are registered from the next-state decode, so they are
  // glitch-free and carry no combinational path from either ack.
  logic       imem_req_q, imem_req_d;
  logic       dmem_req_q, dmem_req_d;
  logic       dmem_we_q,  dmem_we_d;
  logic       pc_we_q,    pc_we_d;
  logic       rf_we_q,    rf_we_d;
  logic       alu_src_q,  alu_src_d;
  logic [2:0] alu_op_q,   alu_op_d;
  logic       halt_q,     halt_d;
  logic       alu_en;

  logic       dec_legal, dec_mem, dec_store, dec_wr_rd, dec_alu_src;
  logic [2:0] dec_alu_op;

  // Only the opcode field of the instruction matters to the sequencer.
  logic unused_inst;
  assign unused_inst = ^inst[31:7];

  // The opcode only changes when the IR is loaded; everywhere else op_d == op_q,
  // so a single decoder on op_d serves both the transitions and the output decode.
  assign op_d = (state_q == ST_FETCH && imem_ack) ? inst[6:0] : op_q;

  seq_opcode_dec u_dec (
    .op_i     (op_d),
    .is_legal (dec_legal),
    .is_mem   (dec_mem),
    .is_store (dec_store),
    .wr_rd    (dec_wr_rd),
    .alu_src  (dec_alu_src),
    .alu_op   (dec_alu_op)
  );

  // Next state. The timeout counter defaults to 0, which clears it on entry to
  // FETCH/MEM and on every ack; it only counts while a request waits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    instret_d = instret_q;
    trap_d    = trap_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // An ack in the limit cycle takes priority over the timeout.
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d = ST_HALT;
          trap_d  = TRAP_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (op_q == OPC_EBREAK) begin
          state_d = ST_HALT;
          trap_d  = TRAP_EBREAK;
        end else if (!dec_legal) begin
          state_d = ST_HALT;
          trap_d  = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = dec_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d = ST_HALT;
          trap_d  = TRAP_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        state_d   = ST_FETCH;
        instret_d = instret_q + 64'd1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    alu_en     = (state_d == ST_DECODE) || (state_d == ST_EXEC) ||
                 (state_d == ST_MEM)    || (state_d == ST_WB);
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && dec_store;
    pc_we_d    = (state_d == ST_WB);
    rf_we_d    = (state_d == ST_WB) && dec_wr_rd;
    alu_src_d  = alu_en && dec_alu_src;
    alu_op_d   = alu_en ? dec_alu_op : ALU_OP_NONE;
    halt_d     = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      instret_q  <= '0;
      trap_q     <= TRAP_NONE;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      pc_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      alu_src_q  <= 1'b0;
      alu_op_q   <= ALU_OP_NONE;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      instret_q  <= instret_d;
      trap_q     <= trap_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      pc_we_q    <= pc_we_d;
      rf_we_q    <= rf_we_d;
      alu_src_q  <= alu_src_d;
      alu_op_q   <= alu_op_d;
      halt_q     <= halt_d;
    end
  end

  // IR load strobe is the one Mealy output: it must coincide with the ack cycle.
  assign ir_we    = (state_q == ST_FETCH) && imem_ack;
  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign pc_we    = pc_we_q;
  assign rf_we    = rf_we_q;
  assign alu_src  = alu_src_q;
  assign alu_op   = alu_op_q;
  assign halt     = halt_q;
  assign trap     = trap_q;
  assign instret  = instret_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed and random instruction streams with a scoreboard of
// expected retire/halt events, compared by an independent monitor at each pc_we pulse or halt.
// Latency and wait-cycle counts are derived from the per-phase cycle rules, not from the RTL.
module tb_core_seq_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_EBREAK = 7'b1110011;
  // EBREAK last so indices 0..10 are the ordinary legal opcodes.
  localparam logic [6:0] LEGAL_OPS [12] = '{
    7'b0110111, 7'b0010111, 7'b0010011, 7'b0011011, 7'b0111011, 7'b0110011,
    7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_src, halt;
  logic [2:0]  alu_op, state_o;
  logic [1:0]  trap;
  logic [63:0] instret;

  core_seq_ctrl #(.BUS_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .alu_src(alu_src), .alu_op(alu_op), .halt(halt),
    .trap(trap), .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_halt;
    bit              rf_we;
    bit [3:0]        alu;
    bit [1:0]        trap;
    longint unsigned instret;
    int              lat;
    int              mreq;
    int              mwe;
  } exp_t;

  exp_t            sbq[$];
  int              total = 0;
  int              bad = 0;
  longint unsigned retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [6:0] op);
    foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   fstart = 0;
  int   mreq_n = 0;
  int   mwe_n = 0;
  bit   p_req = 0;
  bit   p_halt = 0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_req  = 0;
      p_halt = 0;
    end else begin
      if (imem_req && !p_req) begin
        fstart = cyc;
        mreq_n = 0;
        mwe_n  = 0;
      end
      if (dmem_req) mreq_n++;
      if (dmem_req && dmem_we) mwe_n++;
      if (pc_we || (halt && !p_halt)) begin
        if (sbq.size() == 0) begin
          check("unexpected_event", 64'd1, 64'd0);
        end else begin
          me = sbq.pop_front();
          if (pc_we) begin
            check("kind_retire", 64'(me.is_halt), 64'd0);
            check("rf_we", 64'(rf_we), 64'(me.rf_we));
            check("alu_ctrl_wb", 64'({alu_src, alu_op}), 64'(me.alu));
            check("instret_wb", instret, me.instret);
            check("retire_latency", 64'(cyc - fstart + 1), 64'(me.lat));
            check("dmem_req_cycles", 64'(mreq_n), 64'(me.mreq));
            check("dmem_we_cycles", 64'(mwe_n), 64'(me.mwe));
          end else begin
            check("kind_halt", 64'(me.is_halt), 64'd1);
            check("trap", 64'(trap), 64'(me.trap));
            check("instret_halt", instret, me.instret);
            check("halt_latency", 64'(cyc - fstart), 64'(me.lat));
          end
        end
      end
      p_req  = imem_req;
      p_halt = halt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic rst_release();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("state_after_release", 64'(state_o), 64'd0);
    @(negedge clk);
    check("state_fetch_after_idle", 64'(state_o), 64'd1);
    check("instret_after_reset", instret, 64'd0);
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1 check("reset_outputs",
             64'({imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_src, alu_op, halt, trap, state_o}),
             64'd0);
    check("reset_instret", instret, 64'd0);
    sbq.delete();
    retired = 0;
    rst_release();
  endtask

  // iwait/dwait < 0 means that request is never acknowledged.
  task automatic issue(input logic [31:0] ins, input int iwait, input int dwait);
    exp_t       e;
    logic [6:0] op;
    bit         mem;
    int         n;
    op = ins[6:0];
    mem = (op == OPC_LOAD) || (op == OPC_STORE);
    e.is_halt = 1'b0; e.rf_we = 1'b0; e.alu = 4'h0; e.trap = 2'd0;
    e.instret = retired; e.lat = 0; e.mreq = 0; e.mwe = 0;
    if (iwait < 0) begin
      e.is_halt = 1'b1; e.trap = 2'd3; e.lat = TO + 1;
    end else if (op == OPC_EBREAK) begin
      e.is_halt = 1'b1; e.trap = 2'd1; e.lat = iwait + 2;
    end else if (!ref_legal(op)) begin
      e.is_halt = 1'b1; e.trap = 2'd2; e.lat = iwait + 2;
    end else if (mem && dwait < 0) begin
      e.is_halt = 1'b1; e.trap = 2'd3; e.lat = iwait + 4 + TO;
    end else begin
      e.rf_we = !(op == OPC_BRANCH || op == OPC_STORE);
      e.alu   = (op == OPC_OP_IMM) ? 4'b1011 : 4'b0000;
      e.mreq  = mem ? dwait + 1 : 0;
      e.mwe   = (op == OPC_STORE) ? e.mreq : 0;
      e.lat   = 4 + iwait + e.mreq;
      retired++;
    end
    sbq.push_back(e);

    n = 0;
    while (!imem_req && n < 64) begin @(negedge clk); n++; end
    if (!imem_req) begin check("imem_req_seen", 64'd0, 64'd1); return; end
    if (iwait < 0) return;
    repeat (iwait) @(negedge clk);
    inst = ins;
    imem_ack = 1'b1;
    #1 check("ir_we_on_ack", 64'(ir_we), 64'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    inst = '0;
    if (!mem) return;

    n = 0;
    while (!dmem_req && n < 64) begin @(negedge clk); n++; end
    if (!dmem_req) begin check("dmem_req_seen", 64'd0, 64'd1); return; end
    if (dwait < 0) return;
    repeat (dwait) @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halt && n < 64) begin @(negedge clk); n++; end
    check("halt_reached", 64'(halt), 64'd1);
    repeat (20) begin
      @(negedge clk);
      check("halt_quiet", 64'({halt, imem_req, dmem_req, pc_we, rf_we, ir_we}), 64'b100000);
    end
  endtask

  function automatic logic [31:0] rand_inst(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], op};
  endfunction

  initial begin
    int           n;
    int           kind;
    logic [6:0]   op;
    logic [31:0]  r;

    // Directed: addi, sd with 3 wait cycles, ebreak.
    do_reset();
    issue(32'h00100093, 0, 0);
    issue(32'h00113023, 0, 3);
    issue(32'h00100073, 0, 0);
    wait_halt();

    // Illegal opcode after one retired instruction.
    do_reset();
    issue(32'h00000013, 1, 0);
    issue(32'h0000007F, 1, 0);
    wait_halt();

    // Fetch timeout; then ack exactly at the limit cycle in both FETCH and MEM.
    do_reset();
    issue(32'h0, -1, 0);
    wait_halt();
    do_reset();
    issue(32'h00100093, TO, 0);
    issue(32'h00003083, TO, TO);
    issue(32'h00003083, 0, -1);
    wait_halt();

    // Random streams, each ended by a random halt cause.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      n = $urandom_range(2, 8);
      for (int k = 0; k < n; k++) begin
        op = LEGAL_OPS[$urandom_range(0, 10)];
        issue(rand_inst(op), $urandom_range(0, TO), $urandom_range(0, TO));
      end
      kind = $urandom_range(0, 3);
      case (kind)
        0: issue(rand_inst(OPC_EBREAK), $urandom_range(0, TO), 0);
        1: begin
          do begin
            r = $urandom_range(0, 127);
            op = r[6:0];
          end while (ref_legal(op));
          issue(rand_inst(op), $urandom_range(0, TO), 0);
        end
        2: issue(32'h0, -1, 0);
        default: issue(rand_inst(($urandom_range(0, 1) != 0) ? OPC_LOAD : OPC_STORE),
                       $urandom_range(0, TO), -1);
      endcase
      wait_halt();
    end

    // Asynchronous reset while a load is waiting in MEM.
    do_reset();
    issue(32'h00100093, 0, 0);
    n = 0;
    while (!imem_req && n < 64) begin @(negedge clk); n++; end
    inst = 32'h00003083;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (!dmem_req && n < 64) begin @(negedge clk); n++; end
    check("mem_reached_before_reset", 64'(dmem_req), 64'd1);
    check("instret_before_reset", instret, 64'd1);
    #2 rst = 1'b1;
    #1 check("dmem_req_async_drop", 64'({dmem_req, dmem_we, state_o}), 64'd0);
    check("instret_async_clear", instret, 64'd0);
    sbq.delete();
    rst_release();
    check("sb_final", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
